// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the CPU/DMA single-port memory arbiter.
package mem_arb_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 9;

    typedef enum logic {IDLE, DMA_BURST} state_t;
    typedef enum logic {OWN_CPU, OWN_DMA} owner_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of CPU port, DMA port and memory command/response signals around mem_arbiter.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              cpu_req;
    logic              cpu_wr;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_gnt;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              dma_req;
    logic              dma_wr;
    logic              dma_last;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic              dma_rvalid;
    logic [DATA_W-1:0] dma_rdata;

    logic              mem_wr;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_gnt, cpu_rvalid, cpu_rdata,
        input  dma_req, dma_wr, dma_last, dma_addr, dma_wdata,
        output dma_gnt, dma_rvalid, dma_rdata,
        output mem_wr, mem_rd, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_gnt, cpu_rvalid, cpu_rdata,
        output dma_req, dma_wr, dma_last, dma_addr, dma_wdata,
        input  dma_gnt, dma_rvalid, dma_rdata,
        input  mem_wr, mem_rd, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// Two-port (CPU/DMA) arbiter onto a single-port memory: alternating priority in IDLE,
// DMA bursts capped at MAX_BURST beats so a waiting CPU is never starved.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    mem_arbiter_if.slave bus
);

    localparam int             CNT_W    = $clog2(MAX_BURST);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    state_t            state, state_n;
    owner_t            prio, prio_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              cpu_win, dma_win;
    logic              rd_pend;
    owner_t            rd_owner;

    logic              sel_wr, sel_rd;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Grants are forced low during reset so nothing reaches the memory until it is released.
    always_comb begin
        cpu_win = 1'b0;
        dma_win = 1'b0;
        state_n = state;
        prio_n  = prio;
        cnt_n   = cnt;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (bus.cpu_req && (!bus.dma_req || prio == OWN_CPU)) begin
                        cpu_win = 1'b1;
                        prio_n  = OWN_DMA;
                    end else if (bus.dma_req) begin
                        dma_win = 1'b1;
                        if (bus.dma_last) begin
                            prio_n = OWN_CPU;
                        end else begin
                            state_n = DMA_BURST;
                            cnt_n   = CNT_W'(1);
                        end
                    end
                end
                DMA_BURST: begin
                    dma_win = bus.dma_req;
                    cnt_n   = cnt + CNT_W'(1);
                    if (!bus.dma_req || bus.dma_last || cnt == CNT_LAST) begin
                        state_n = IDLE;
                        prio_n  = OWN_CPU;
                        cnt_n   = '0;
                    end
                end
            endcase
        end
    end

    always_comb begin
        sel_wr    = 1'b0;
        sel_rd    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        if (cpu_win) begin
            sel_wr    = bus.cpu_wr;
            sel_rd    = !bus.cpu_wr;
            sel_addr  = bus.cpu_addr;
            sel_wdata = bus.cpu_wdata;
        end else if (dma_win) begin
            sel_wr    = bus.dma_wr;
            sel_rd    = !bus.dma_wr;
            sel_addr  = bus.dma_addr;
            sel_wdata = bus.dma_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            prio     <= OWN_CPU;
            cnt      <= '0;
            rd_pend  <= 1'b0;
            rd_owner <= OWN_CPU;
        end else begin
            state    <= state_n;
            prio     <= prio_n;
            cnt      <= cnt_n;
            rd_pend  <= sel_rd;
            rd_owner <= dma_win ? OWN_DMA : OWN_CPU;
        end
    end

    assign bus.cpu_gnt    = cpu_win;
    assign bus.dma_gnt    = dma_win;
    assign bus.mem_wr     = sel_wr;
    assign bus.mem_rd     = sel_rd;
    assign bus.mem_addr   = sel_addr;
    assign bus.mem_wdata  = sel_wdata;

    // Read data is steered only to the port that issued the read; the other port sees zero.
    assign bus.cpu_rvalid = rd_pend && (rd_owner == OWN_CPU);
    assign bus.dma_rvalid = rd_pend && (rd_owner == OWN_DMA);
    assign bus.cpu_rdata  = bus.cpu_rvalid ? bus.mem_rdata : '0;
    assign bus.dma_rdata  = bus.dma_rvalid ? bus.mem_rdata : '0;

endmodule
